// File: rtl/latch_pkg.sv
// Shared types and default sizing for the tr_latch capture stage.
package latch_pkg;

    localparam int DEF_WIDTH       = 8;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_CNT_W       = 8;
    localparam int DEF_BITCNT_W    = $clog2(DEF_WIDTH);

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_t;

    // Bits needed to index a bit position inside a frame of the given width.
    function automatic int bitcnt_width(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/latch_capture_sync_chain.sv
// Multi-flop synchroniser for a single asynchronous input; reusable for any such signal.
module sync_chain
    import latch_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] chain_r;

    // Shift the asynchronous input through the metastability chain.
    always_ff @(posedge clock) begin
        if (reset) begin
            chain_r <= '0;
        end else begin
            chain_r <= {chain_r[SYNC_STAGES-2:0], d};
        end
    end

    assign q = chain_r[SYNC_STAGES-1];

endmodule

// File: rtl/latch_capture.sv
// Synchronises tr_latch q_out, detects/counts its edges and deserialises it
// into frames delivered over a valid/ready handshake.
module latch_capture
    import latch_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             q_in,
    input  logic             sample_en,
    input  logic             clear_cnt,
    input  logic             frame_ready,
    output logic [WIDTH-1:0] frame_data,
    output logic             frame_valid,
    output logic             edge_rise,
    output logic             edge_fall,
    output logic [CNT_W-1:0] edge_count,
    output logic             overrun
);

    localparam int                   BITCNT_W = bitcnt_width(WIDTH);
    localparam logic [BITCNT_W-1:0]  LAST_BIT = BITCNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0]     CNT_MAX  = '1;

    logic                sync_s;
    logic                prev_r;
    state_t              state_r;
    logic [WIDTH-1:0]    shreg_r;
    logic [BITCNT_W-1:0] bitcnt_r;
    logic [WIDTH-1:0]    next_frame_s;
    logic                complete_s;
    logic                take_s;

    sync_chain #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clock (clock),
        .reset (reset),
        .d     (q_in),
        .q     (sync_s)
    );

    assign next_frame_s = {shreg_r[WIDTH-2:0], sync_s};

    // Frame completion and whether the frame register can take a new frame this cycle.
    always_comb begin
        complete_s = 1'b0;
        take_s     = 1'b0;
        if ((state_r == FILL) && sample_en && (bitcnt_r == LAST_BIT)) begin
            complete_s = 1'b1;
        end else begin
            complete_s = 1'b0;
        end
        if (!frame_valid || frame_ready) begin
            take_s = 1'b1;
        end else begin
            take_s = 1'b0;
        end
    end

    // Registered edge pulses and the saturating transition counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            prev_r     <= 1'b0;
            edge_rise  <= 1'b0;
            edge_fall  <= 1'b0;
            edge_count <= '0;
        end else begin
            prev_r    <= sync_s;
            edge_rise <= sync_s & ~prev_r;
            edge_fall <= ~sync_s & prev_r;
            if (clear_cnt) begin
                edge_count <= '0;
            end else if ((sync_s != prev_r) && (edge_count != CNT_MAX)) begin
                edge_count <= edge_count + CNT_W'(1);
            end
        end
    end

    // Deserialiser FSM plus frame register; a completed frame that cannot be held is dropped.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r     <= IDLE;
            shreg_r     <= '0;
            bitcnt_r    <= '0;
            frame_data  <= '0;
            frame_valid <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            overrun <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (sample_en) begin
                        state_r <= FILL;
                    end
                end
                FILL: begin
                    if (sample_en) begin
                        shreg_r <= next_frame_s;
                        if (bitcnt_r == LAST_BIT) begin
                            bitcnt_r <= '0;
                        end else begin
                            bitcnt_r <= bitcnt_r + BITCNT_W'(1);
                        end
                    end else begin
                        state_r  <= IDLE;
                        shreg_r  <= '0;
                        bitcnt_r <= '0;
                    end
                end
                default: begin
                    state_r  <= IDLE;
                    shreg_r  <= '0;
                    bitcnt_r <= '0;
                end
            endcase

            if (complete_s) begin
                if (take_s) begin
                    frame_data  <= next_frame_s;
                    frame_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (frame_valid && frame_ready) begin
                frame_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/latch_capture.md
Name: latch_capture

Overview:
Clocked capture stage directly downstream of the transparent data latch (tr_latch). It synchronises the latch's asynchronous q_out into the system clock domain and detects its rising and falling edges. It counts transitions and, while sampling is enabled, deserialises one bit per clock into WIDTH-bit frames. Frames are handed on over a valid/ready handshake.

Parameters:
WIDTH, 8, bits per captured frame (>=2)
SYNC_STAGES, 2, synchroniser flops on q_in (>=2)
CNT_W, 8, width of saturating transition counter

Ports:
clock  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
q_in  input  1  latch output (asynchronous to clock)
sample_en  input  1  enables frame deserialisation
clear_cnt  input  1  synchronous clear of edge_count
frame_ready  input  1  downstream accepts frame_data
frame_data  output  WIDTH  last completed frame, first-sampled bit in MSB
frame_valid  output  1  frame_data holds an unaccepted frame
edge_rise  output  1  one-cycle pulse on synchronised 0->1
edge_fall  output  1  one-cycle pulse on synchronised 1->0
edge_count  output  CNT_W  saturating count of synchronised transitions
overrun  output  1  one-cycle pulse: completed frame dropped

Behaviour:
- Reset (synchronous, active-high) wins over everything. It clears all outputs, sync chain, prev, shift register, bit counter and state (IDLE) to 0.
- Reset mid-frame discards the partial frame and any held frame.
- Sync chain: sync[0]<=q_in; sync[k]<=sync[k-1]; s = sync[SYNC_STAGES-1]. prev<=s every cycle.
- Edge outputs are registered: edge_rise<=s&~prev; edge_fall<=~s&prev.
- Latency: a q_in change set up before edge 1 gives an edge pulse high after edge SYNC_STAGES+1 (edge 3 for the default), for exactly one cycle.
- Sync chain and prev reset to 0, so q_in=1 at reset release yields one edge_rise.
- edge_count: increments by 1 on each cycle where s!=prev. It saturates at 2^CNT_W-1 with no wrap.
- clear_cnt has priority over increment and sets edge_count to 0.
- FSM, two states:
  - IDLE: no shifting. On an edge with sample_en=1, go to FILL. No bit is captured on that edge.
  - FILL, sample_en=1: shreg<={shreg[WIDTH-2:0], s}; bitcnt++.
  - FILL, sample_en=0: return to IDLE. Clear shreg and bitcnt; the partial frame is discarded silently with no overrun.
- First data bit is captured on the second edge after sample_en rises.
- Frame completion is a FILL shift with bitcnt==WIDTH-1. On completion, bitcnt<=0, state stays FILL, and the next frame starts on the next edge with no gap.
  - If frame_valid==0 or frame_ready==1: frame_data<={shreg[WIDTH-2:0], s}; frame_valid<=1.
  - Otherwise: frame_data is held, the new frame is dropped, and overrun pulses for 1 cycle.
- Handshake: a transfer occurs on an edge with frame_valid&frame_ready.
  - Transfer without a same-cycle completion: frame_valid<=0.
  - Transfer with a same-cycle completion: load the new frame and keep frame_valid=1 (back-to-back, no overrun).
- frame_data is stable while frame_valid=1 and is not accepted.
- frame_ready while frame_valid=0 is ignored.

Decomposition:
- Package latch_pkg:
  - state type (IDLE, FILL)
  - default constants for WIDTH, SYNC_STAGES, CNT_W
  - bit-counter width, computed as clog2(WIDTH)
- One sub-module: sync_chain, parameterised by SYNC_STAGES, clock and reset only. It is reusable for other asynchronous inputs.
- Edge detect, counter, FSM and frame register stay in latch_capture.

Test Plan:
1. Reset asserted 3 cycles, q_in=0, sample_en=0 -> all outputs 0, edge_count=0. Then release, idle 10 cycles -> no pulses.
2. q_in 0->1 before edge 1 -> edge_rise high after edge 3 for one cycle, edge_count=1. Then q_in 1->0 -> edge_fall one cycle, edge_count=2.
3. sample_en=1, frame_ready=1, q_in driven MSB-first with 1,0,1,0,0,1,1,0 aligned to capture edges -> frame_data=8'hA6 and frame_valid=1 for one cycle, then frame_valid=0.
4. frame_ready=0, two consecutive frames 8'h3C then 8'hFF -> frame_data stays 8'h3C and overrun pulses once. Then frame_ready=1 -> frame_valid falls next edge.
5. sample_en dropped after 5 captured bits -> no frame_valid, no overrun. Re-assert and send 8'h81 -> frame_data=8'h81. Reset asserted mid-frame -> all cleared and no frame emitted.
6. 300 synchronised toggles with CNT_W=8 -> edge_count=255 held. clear_cnt for 1 cycle concurrent with a toggle -> edge_count=0, and the next toggle gives 1.
